lsu_param: RTL and testbench

//  Parametrised per-thread load/store unit; one instance per thread per core.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_wait_timer.sv | 40 ++++
 rtl/lsu_param.sv | 161 ++++++++++++++++
 tb/tb_lsu_param.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the per-thread load/store unit.
// Optional wait timeout is built when LSU_TIMEOUT_EN is defined.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUESTING = 2'd1,
        WAITING    = 2'd2,
        DONE       = 2'd3
    } lsu_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } lsu_op_t;

    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    // Loads win when the decoder flags both a load and a store.
    function automatic lsu_op_t select_op(input logic rd_en, input logic wr_en);
        select_op = (rd_en || !wr_en) ? OP_READ : OP_WRITE;
    endfunction

endpackage

// File: rtl/lsu_wait_timer.sv
// Bounded-wait counter for the LSU; flags expiry on the cycle the count
// would reach TIMEOUT_CYCLES. Only instantiated when LSU_TIMEOUT_EN is defined.
module lsu_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAX_COUNT  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_i && (count_q != MAX_COUNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The abort edge is the one on which this idle cycle brings the count to the limit.
    assign expire_o = count_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/lsu_param.sv
// Per-thread load/store unit: one LDR/STR per instruction over separate
// read/write valid-ready channels. Define LSU_TIMEOUT_EN for the bounded wait.
module lsu_param
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2:0]            core_state,
    input  logic                  decoded_mem_read_enable,
    input  logic                  decoded_mem_write_enable,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    output logic                  mem_read_valid,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic                  mem_read_ready,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_write_valid,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_write_ready,
    output logic [1:0]            lsu_state,
    output logic [DATA_WIDTH-1:0] lsu_out,
    output logic                  lsu_error
);

    lsu_state_t            state_q, state_d;
    lsu_op_t               op_q, op_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  error_q, error_d;

    logic [ADDR_WIDTH-1:0] rs_addr;
    logic                  ready_sel;
    logic                  timeout_hit;

    generate
        if (ADDR_WIDTH <= DATA_WIDTH) begin : g_addr_trunc
            assign rs_addr = rs[ADDR_WIDTH-1:0];
        end else begin : g_addr_zext
            assign rs_addr = {{(ADDR_WIDTH - DATA_WIDTH){1'b0}}, rs};
        end
    endgenerate

    assign ready_sel = (op_q == OP_READ) ? mem_read_ready : mem_write_ready;

`ifdef LSU_TIMEOUT_EN
    lsu_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (enable && (state_q == REQUESTING)),
        .count_i  (enable && (state_q == WAITING) && !ready_sel),
        .expire_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        out_d      = out_q;
        error_d    = error_q;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if ((core_state == CORE_REQUEST) &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        op_d    = select_op(decoded_mem_read_enable, decoded_mem_write_enable);
                        state_d = REQUESTING;
                    end
                end
                REQUESTING: begin
                    if (op_q == OP_READ) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = rs_addr;
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = rs_addr;
                        wr_data_d  = rt;
                    end
                    state_d = WAITING;
                end
                WAITING: begin
                    // Ready beats the timeout when both land on the same cycle.
                    if (ready_sel) begin
                        if (op_q == OP_READ) begin
                            out_d      = mem_read_data;
                            rd_valid_d = 1'b0;
                        end else begin
                            wr_valid_d = 1'b0;
                        end
                        state_d = DONE;
                    end else if (timeout_hit) begin
                        rd_valid_d = 1'b0;
                        wr_valid_d = 1'b0;
                        error_d    = 1'b1;
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    if (core_state == CORE_UPDATE) begin
                        error_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= OP_READ;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            out_q      <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            out_q      <= out_d;
            error_q    <= error_d;
        end
    end

    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = rd_addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_data    = wr_data_q;
    assign lsu_state         = state_q;
    assign lsu_out           = out_q;
    assign lsu_error         = error_q;

endmodule

// File: tb/tb_lsu_param.sv
// Directed bench for lsu_param; the timeout scenario runs when LSU_TIMEOUT_EN is defined.
module tb_lsu_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic [2:0] core_state = 3'b000;
    logic       rd_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] rs = 8'h00;
    logic [7:0] rt = 8'h00;
    logic       mem_read_valid;
    logic [7:0] mem_read_address;
    logic       mem_read_ready = 1'b0;
    logic [7:0] mem_read_data = 8'h00;
    logic       mem_write_valid;
    logic [7:0] mem_write_address;
    logic [7:0] mem_write_data;
    logic       mem_write_ready = 1'b0;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] REQ = 3'b011;
    localparam logic [2:0] UPD = 3'b110;

    lsu_param #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .rs                       (rs),
        .rt                       (rt),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out),
        .lsu_error                (lsu_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_state", lsu_state, 2'd0);
        chk("rst_rvalid", mem_read_valid, 1'b0);
        chk("rst_wvalid", mem_write_valid, 1'b0);
        chk("rst_out", lsu_out, 8'h00);
        chk("rst_err", lsu_error, 1'b0);
        reset = 1'b1;

        // 1: LDR rs=0x2A, ready two cycles after valid, data 0xC3
        rs = 8'h2A; rd_en = 1'b1; core_state = REQ;
        tick();
        chk("t1_requesting", lsu_state, 2'd1);
        core_state = 3'b000;
        tick();
        chk("t1_waiting", lsu_state, 2'd2);
        chk("t1_rvalid", mem_read_valid, 1'b1);
        chk("t1_raddr", mem_read_address, 8'h2A);
        tick();
        chk("t1_still_wait", lsu_state, 2'd2);
        mem_read_ready = 1'b1; mem_read_data = 8'hC3;
        tick();
        mem_read_ready = 1'b0;
        chk("t1_done", lsu_state, 2'd3);
        chk("t1_out", lsu_out, 8'hC3);
        chk("t1_rvalid_drop", mem_read_valid, 1'b0);
        tick();
        chk("t1_hold_done", lsu_state, 2'd3);
        core_state = UPD;
        tick();
        core_state = 3'b000;
        chk("t1_idle", lsu_state, 2'd0);
        $display("txn1 LDR addr=2a data=c3 out=%0h", lsu_out);

        // 2: STR rs=0x10 rt=0x5A; ready also high during REQUESTING (must be ignored)
        rd_en = 1'b0; wr_en = 1'b1; rs = 8'h10; rt = 8'h5A; core_state = REQ;
        tick();
        core_state = 3'b000;
        mem_write_ready = 1'b1;
        tick();
        chk("t2_waiting", lsu_state, 2'd2);
        chk("t2_wvalid", mem_write_valid, 1'b1);
        chk("t2_waddr", mem_write_address, 8'h10);
        chk("t2_wdata", mem_write_data, 8'h5A);
        chk("t2_rvalid_quiet", mem_read_valid, 1'b0);
        tick();
        mem_write_ready = 1'b0;
        chk("t2_done", lsu_state, 2'd3);
        chk("t2_wvalid_drop", mem_write_valid, 1'b0);
        chk("t2_out_kept", lsu_out, 8'hC3);
        core_state = UPD;
        tick();
        core_state = 3'b000;
        chk("t2_idle", lsu_state, 2'd0);
        $display("txn2 STR addr=10 data=5a");

        // 3: both enables set -> read only, write port untouched
        rd_en = 1'b1; wr_en = 1'b1; rs = 8'h07; rt = 8'h99; core_state = REQ;
        tick();
        core_state = 3'b000;
        tick();
        chk("t3_rvalid", mem_read_valid, 1'b1);
        chk("t3_raddr", mem_read_address, 8'h07);
        chk("t3_wvalid", mem_write_valid, 1'b0);
        chk("t3_waddr_kept", mem_write_address, 8'h10);
        chk("t3_wdata_kept", mem_write_data, 8'h5A);
        mem_read_ready = 1'b1; mem_read_data = 8'h3C;
        tick();
        mem_read_ready = 1'b0;
        chk("t3_out", lsu_out, 8'h3C);
        core_state = UPD;
        tick();
        core_state = 3'b000;
        chk("t3_idle", lsu_state, 2'd0);
        $display("txn3 LDR+STR addr=07 out=%0h", lsu_out);

        // 4: enable low for three WAITING cycles, ready present but ignored
        wr_en = 1'b0; rs = 8'h55; core_state = REQ;
        tick();
        core_state = 3'b000;
        tick();
        enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_frozen_state", lsu_state, 2'd2);
            chk("t4_frozen_valid", mem_read_valid, 1'b1);
        end
        chk("t4_frozen_out", lsu_out, 8'h3C);
        enable = 1'b1;
        tick();
        mem_read_ready = 1'b0;
        chk("t4_done", lsu_state, 2'd3);
        chk("t4_out", lsu_out, 8'h77);
        core_state = UPD;
        tick();
        core_state = 3'b000;
        chk("t4_idle", lsu_state, 2'd0);
        $display("txn4 LDR addr=55 frozen 3 cycles out=%0h", lsu_out);

`ifdef LSU_TIMEOUT_EN
        // 6: LDR with no ready; aborts after 4 WAITING cycles
        rs = 8'h44; core_state = REQ;
        tick();
        core_state = 3'b000;
        tick();
        chk("t6_wait0", mem_read_valid, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t6_wait_state", lsu_state, 2'd2);
            chk("t6_wait_valid", mem_read_valid, 1'b1);
        end
        tick();
        chk("t6_done", lsu_state, 2'd3);
        chk("t6_valid_drop", mem_read_valid, 1'b0);
        chk("t6_err", lsu_error, 1'b1);
        chk("t6_out_kept", lsu_out, 8'h77);
        core_state = UPD;
        tick();
        core_state = 3'b000;
        chk("t6_idle", lsu_state, 2'd0);
        chk("t6_err_clr", lsu_error, 1'b0);
        $display("txn6 LDR addr=44 timeout err=%0b", lsu_error);
`endif

        // 5: async reset while WAITING on a store
        rd_en = 1'b0; wr_en = 1'b1; rs = 8'h20; rt = 8'h33; core_state = REQ;
        tick();
        core_state = 3'b000;
        tick();
        chk("t5_wvalid", mem_write_valid, 1'b1);
        chk("t5_err_none", lsu_error, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_valid", mem_write_valid, 1'b0);
        chk("t5_rst_state", lsu_state, 2'd0);
        chk("t5_rst_waddr", mem_write_address, 8'h00);
        chk("t5_rst_out", lsu_out, 8'h00);
        #2;
        reset = 1'b1;
        tick();
        chk("t5_after_rst", lsu_state, 2'd0);
        $display("txn5 STR addr=20 reset mid-wait");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
